// File: rtl/breakout_pkg.sv
// Shared types and defaults for the breakout game sequencer.
// State encodings, playfield constants and the BCD digit type.
package breakout_pkg;

    typedef enum logic [2:0] {
        ST_NEWGAME = 3'd0,
        ST_PLAY    = 3'd1,
        ST_NEWBALL = 3'd2,
        ST_OVER    = 3'd3,
        ST_WIN     = 3'd4
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int NUM_BRICKS_DEF  = 48;
    localparam int LIVES_INIT_DEF  = 3;
    localparam int DELAY_TICKS_DEF = 120;

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter with synchronous clear and increment.
// Counts 00..99 and wraps back to 00.
module bcd_counter2
    import breakout_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output bcd_t o_d1,
    output bcd_t o_d0
);

    bcd_t r_d1;
    bcd_t r_d0;

    // Clear wins over increment; units carry into tens, 99 wraps to 00.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d1 <= 4'd0;
            r_d0 <= 4'd0;
        end else if (i_clr) begin
            r_d1 <= 4'd0;
            r_d0 <= 4'd0;
        end else if (i_inc) begin
            if (r_d0 == 4'd9) begin
                r_d0 <= 4'd0;
                r_d1 <= (r_d1 == 4'd9) ? 4'd0 : r_d1 + 4'd1;
            end else begin
                r_d0 <= r_d0 + 4'd1;
            end
        end
    end

    assign o_d1 = r_d1;
    assign o_d0 = r_d0;

endmodule

// File: rtl/breakout_game_ctrl.sv
// Game-level sequencer: freezes the playfield, tracks lives,
// score and bricks, and times the pauses between balls/games.
module breakout_game_ctrl
    import breakout_pkg::*;
#(
    parameter int NUM_BRICKS  = NUM_BRICKS_DEF,
    parameter int LIVES_INIT  = LIVES_INIT_DEF,
    parameter int DELAY_TICKS = DELAY_TICKS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] i_btn,
    input  logic       i_refr_tick,
    input  logic       i_hit,
    input  logic       i_miss,
    output logic       o_gra_still,
    output logic [2:0] o_game_state,
    output logic [1:0] o_lives,
    output logic [3:0] o_score_d1,
    output logic [3:0] o_score_d0,
    output logic [5:0] o_bricks_left
);

    localparam logic [5:0] BRICKS_RLD = 6'(NUM_BRICKS);
    localparam logic [1:0] LIVES_RLD  = 2'(LIVES_INIT);
    localparam logic [7:0] TIMER_RLD  = 8'(DELAY_TICKS);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_hit_q;
    logic       r_miss_q;
    logic [7:0] r_timer;
    logic [1:0] r_lives;
    logic [5:0] r_bricks;

    logic w_hit_ev;
    logic w_miss_ev;
    logic w_btn;
    logic w_timer_done;
    logic w_win;
    logic w_score_inc;
    logic w_brick_dec;
    logic w_life_dec;
    logic w_reload;
    logic w_timer_load;

    bcd_t w_d1;
    bcd_t w_d0;

    assign w_hit_ev     = i_hit & ~r_hit_q;
    assign w_miss_ev    = i_miss & ~r_miss_q;
    assign w_btn        = |i_btn;
    assign w_timer_done = (r_timer == 8'd0);
    assign w_win        = w_hit_ev & (r_bricks == 6'd1);

    // Rising-edge history for the hit/miss levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_q  <= 1'b0;
            r_miss_q <= 1'b0;
        end else begin
            r_hit_q  <= i_hit;
            r_miss_q <= i_miss;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_NEWGAME;
        else       r_state <= w_state_nxt;
    end

    // Next state and per-cycle counter controls; events only count in PLAY.
    always_comb begin
        w_state_nxt  = r_state;
        w_score_inc  = 1'b0;
        w_brick_dec  = 1'b0;
        w_life_dec   = 1'b0;
        w_reload     = 1'b0;
        w_timer_load = 1'b0;
        case (r_state)
            ST_NEWGAME: begin
                if (w_btn) w_state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (w_hit_ev) begin
                    w_score_inc = 1'b1;
                    w_brick_dec = (r_bricks != 6'd0);
                end
                if (w_win) begin
                    w_state_nxt  = ST_WIN;
                    w_timer_load = 1'b1;
                end else if (w_miss_ev) begin
                    w_life_dec   = (r_lives != 2'd0);
                    w_timer_load = 1'b1;
                    w_state_nxt  = (r_lives == 2'd1) ? ST_OVER : ST_NEWBALL;
                end
            end
            ST_NEWBALL: begin
                if (w_timer_done && w_btn) w_state_nxt = ST_PLAY;
            end
            ST_OVER, ST_WIN: begin
                if (w_timer_done) begin
                    w_state_nxt = ST_NEWGAME;
                    w_reload    = 1'b1;
                end
            end
            default: w_state_nxt = ST_NEWGAME;
        endcase
    end

    // Pause timer: load on entering a pause, count down on frame ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_timer <= 8'd0;
        else if (w_timer_load)
            r_timer <= TIMER_RLD;
        else if (i_refr_tick && !w_timer_done)
            r_timer <= r_timer - 8'd1;
    end

    // Lives and brick counters, reloaded when a finished game restarts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lives  <= LIVES_RLD;
            r_bricks <= BRICKS_RLD;
        end else if (w_reload) begin
            r_lives  <= LIVES_RLD;
            r_bricks <= BRICKS_RLD;
        end else begin
            if (w_life_dec)  r_lives  <= r_lives - 2'd1;
            if (w_brick_dec) r_bricks <= r_bricks - 6'd1;
        end
    end

    bcd_counter2 u_score (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_reload),
        .i_inc (w_score_inc),
        .o_d1  (w_d1),
        .o_d0  (w_d0)
    );

    assign o_gra_still   = (r_state != ST_PLAY);
    assign o_game_state  = r_state;
    assign o_lives       = r_lives;
    assign o_score_d1    = w_d1;
    assign o_score_d0    = w_d0;
    assign o_bricks_left = r_bricks;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed bench for breakout_game_ctrl and its BCD score counter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_breakout_game_ctrl;
    import breakout_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] btn = 5'd0;
    logic       refr_tick = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       gra_still;
    logic [2:0] game_state;
    logic [1:0] lives;
    logic [3:0] score_d1;
    logic [3:0] score_d0;
    logic [5:0] bricks_left;

    logic       b_clr = 1'b0;
    logic       b_inc = 1'b0;
    bcd_t       b_d1;
    bcd_t       b_d0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    breakout_game_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .i_btn         (btn),
        .i_refr_tick   (refr_tick),
        .i_hit         (hit),
        .i_miss        (miss),
        .o_gra_still   (gra_still),
        .o_game_state  (game_state),
        .o_lives       (lives),
        .o_score_d1    (score_d1),
        .o_score_d0    (score_d0),
        .o_bricks_left (bricks_left)
    );

    bcd_counter2 u_bcd (
        .clk   (clk),
        .reset (reset),
        .i_clr (b_clr),
        .i_inc (b_inc),
        .o_d1  (b_d1),
        .o_d0  (b_d0)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_miss();
        miss = 1'b1;
        cyc(1);
        miss = 1'b0;
        cyc(1);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            refr_tick = 1'b1;
            cyc(1);
            refr_tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic state_all(input string tag, input int st, input int still,
                             input int lv, input int d1, input int d0,
                             input int br);
        chk({tag, ".state"}, 32'(game_state), 32'(st));
        chk({tag, ".still"}, 32'(gra_still), 32'(still));
        chk({tag, ".lives"}, 32'(lives), 32'(lv));
        chk({tag, ".d1"}, 32'(score_d1), 32'(d1));
        chk({tag, ".d0"}, 32'(score_d0), 32'(d0));
        chk({tag, ".bricks"}, 32'(bricks_left), 32'(br));
    endtask

    initial begin
        cyc(2);
        reset = 1'b0;
        cyc(100);
        state_all("idle", 0, 1, 3, 0, 0, 48);

        btn = 5'h10;
        cyc(1);
        btn = 5'd0;
        chk("start.state", 32'(game_state), 32'd1);
        chk("start.still", 32'(gra_still), 32'd0);

        hit = 1'b1;
        cyc(500);
        hit = 1'b0;
        cyc(1);
        state_all("held_hit", 1, 0, 3, 0, 1, 47);

        repeat (8) pulse_hit();
        state_all("score09", 1, 0, 3, 0, 9, 39);
        pulse_hit();
        state_all("score10", 1, 0, 3, 1, 0, 38);

        b_inc = 1'b1;
        cyc(99);
        b_inc = 1'b0;
        chk("bcd99.d1", 32'(b_d1), 32'd9);
        chk("bcd99.d0", 32'(b_d0), 32'd9);
        b_inc = 1'b1;
        cyc(1);
        b_inc = 1'b0;
        chk("bcdwrap.d1", 32'(b_d1), 32'd0);
        chk("bcdwrap.d0", 32'(b_d0), 32'd0);
        b_inc = 1'b1;
        cyc(3);
        b_inc = 1'b0;
        b_clr = 1'b1;
        cyc(1);
        b_clr = 1'b0;
        chk("bcdclr.d0", 32'(b_d0), 32'd0);

        pulse_miss();
        state_all("miss1", 2, 1, 2, 1, 0, 38);
        pulse_hit();
        chk("nb_hit_ignored.d0", 32'(score_d0), 32'd0);
        chk("nb_hit_ignored.bricks", 32'(bricks_left), 32'd38);

        btn = 5'h01;
        ticks(119);
        chk("nb119.state", 32'(game_state), 32'd2);
        ticks(1);
        btn = 5'd0;
        chk("nb120.state", 32'(game_state), 32'd1);
        chk("nb120.still", 32'(gra_still), 32'd0);

        pulse_miss();
        chk("miss2.lives", 32'(lives), 32'd1);
        btn = 5'h02;
        ticks(120);
        btn = 5'd0;
        chk("resume2.state", 32'(game_state), 32'd1);

        pulse_miss();
        state_all("over", 3, 1, 0, 1, 0, 38);
        ticks(119);
        chk("over119.state", 32'(game_state), 32'd3);
        ticks(1);
        state_all("newgame", 0, 1, 3, 0, 0, 48);

        btn = 5'h04;
        cyc(1);
        btn = 5'd0;
        chk("start2.state", 32'(game_state), 32'd1);
        pulse_miss();
        btn = 5'h08;
        ticks(120);
        btn = 5'd0;
        pulse_miss();
        btn = 5'h08;
        ticks(120);
        btn = 5'd0;
        repeat (47) pulse_hit();
        state_all("prewin", 1, 0, 1, 4, 7, 1);

        hit = 1'b1;
        miss = 1'b1;
        cyc(1);
        hit = 1'b0;
        miss = 1'b0;
        state_all("win", 4, 1, 1, 4, 8, 0);

        ticks(10);
        chk("win_mid.state", 32'(game_state), 32'd4);
        hit = 1'b1;
        reset = 1'b1;
        cyc(1);
        state_all("rst_in", 0, 1, 3, 0, 0, 48);
        reset = 1'b0;
        cyc(2);
        hit = 1'b0;
        state_all("rst_out", 0, 1, 3, 0, 0, 48);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
